// File: rtl/pq_pkg.sv
// Shared definitions for the priority-queue feeder and the queue it drives.
// Holds the controller state encoding and the default sizing constants.
package pq_pkg;

    localparam int PQ_WIDTH     = 1;
    localparam int PQ_DEPTH     = 6;
    localparam int PQ_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pq_state_t;

    // A single-entry buffer still needs a one-bit pointer to be legal.
    function automatic int ptr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pq_fifo.sv
// Small circular input buffer between the producer and the queue controller.
// Pointers wrap modulo BUF_DEPTH; clear discards everything held.
module pq_fifo
    import pq_pkg::*;
#(
    parameter int WIDTH     = PQ_WIDTH,
    parameter int BUF_DEPTH = PQ_BUF_DEPTH
) (
    input  logic             ck,
    input  logic             r,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PW = ptr_bits(BUF_DEPTH);
    localparam int OW = $clog2(BUF_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);
    localparam logic [OW-1:0] CAP  = OW'(BUF_DEPTH);

    logic [WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [OW-1:0]    occ;
    logic             do_push;
    logic             do_pop;

    assign empty   = (occ == '0);
    assign full    = (occ == CAP);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge ck or negedge r) begin
        if (!r) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            // Push and pop together leave occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge ck) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pq_feeder.sv
// Controller that feeds buffered values into a downstream priority queue and
// mirrors its occupancy; every queue command is registered one cycle.
module pq_feeder
    import pq_pkg::*;
#(
    parameter int WIDTH     = PQ_WIDTH,
    parameter int DEPTH     = PQ_DEPTH,
    parameter int BUF_DEPTH = PQ_BUF_DEPTH
) (
    input  logic                       ck,
    input  logic                       r,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       q_loadIn,
    output logic                       q_shiftOut,
    output logic                       q_clear,
    output logic [WIDTH-1:0]           q_newVal,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       err_underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CAP = CW'(DEPTH);

    pq_state_t        state;
    logic             buf_empty;
    logic             buf_full;
    logic             buf_push;
    logic             buf_clear;
    logic [WIDTH-1:0] buf_head;
    logic             do_shift;
    logic             do_load;
    logic             do_underflow;

    assign empty     = (count == '0);
    assign full      = (count == CAP);
    assign in_ready  = (state == RUN) && !buf_full;
    assign buf_push  = in_valid && in_ready;
    assign buf_clear = (state == FLUSH);

    pq_fifo #(
        .WIDTH     (WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .ck        (ck),
        .r         (r),
        .clear     (buf_clear),
        .push      (buf_push),
        .push_data (in_data),
        .pop       (do_load),
        .head      (buf_head),
        .empty     (buf_empty),
        .full      (buf_full)
    );

    // A pop of an empty queue issues no removal, which leaves the slot free for a load.
    always_comb begin
        do_shift     = 1'b0;
        do_load      = 1'b0;
        do_underflow = 1'b0;
        if (state == RUN && !flush) begin
            if (pop && count != '0) begin
                do_shift = 1'b1;
            end else begin
                do_underflow = pop;
                do_load      = !buf_empty && (count != CAP);
            end
        end
    end

    always_ff @(posedge ck or negedge r) begin
        if (!r) begin
            state         <= INIT;
            count         <= '0;
            q_loadIn      <= 1'b0;
            q_shiftOut    <= 1'b0;
            q_clear       <= 1'b0;
            q_newVal      <= '0;
            err_underflow <= 1'b0;
        end else begin
            q_loadIn      <= do_load;
            q_shiftOut    <= do_shift;
            q_clear       <= (state == INIT) || (state == FLUSH);
            q_newVal      <= do_load ? buf_head : '0;
            err_underflow <= do_underflow;

            if (state == FLUSH) begin
                count <= '0;
            end else if (do_shift) begin
                count <= count - CW'(1);
            end else if (do_load) begin
                count <= count + CW'(1);
            end

            case (state)
                INIT:    state <= RUN;
                RUN:     state <= flush ? FLUSH : RUN;
                FLUSH:   state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pq_feeder.sv
// Directed bench for pq_feeder: reset, fill to full, pop while full,
// pop with a concurrent push, underflow, flush and asynchronous reset.
module tb_pq_feeder;

    logic       ck;
    logic       r;
    logic       in_valid;
    logic [0:0] in_data;
    logic       in_ready;
    logic       pop;
    logic       flush;
    logic       q_loadIn;
    logic       q_shiftOut;
    logic       q_clear;
    logic [0:0] q_newVal;
    logic [2:0] count;
    logic       empty;
    logic       full;
    logic       err_underflow;

    int checks = 0;
    int passed = 0;

    logic [0:0] vals [8];

    pq_feeder #(
        .WIDTH     (1),
        .DEPTH     (6),
        .BUF_DEPTH (2)
    ) dut (
        .ck            (ck),
        .r             (r),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .pop           (pop),
        .flush         (flush),
        .q_loadIn      (q_loadIn),
        .q_shiftOut    (q_shiftOut),
        .q_clear       (q_clear),
        .q_newVal      (q_newVal),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .err_underflow (err_underflow)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #2;
    endtask

    // Holds reset across one edge and releases it mid-cycle; the next edge decides the INIT clear.
    task automatic do_reset();
        r        = 1'b0;
        in_valid = 1'b0;
        in_data  = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        @(posedge ck);
        #3;
        r = 1'b1;
    endtask

    task automatic test_reset();
        r = 1'b1; in_valid = 1'b0; in_data = 1'b0; pop = 1'b0; flush = 1'b0;
        #2;
        r = 1'b0;
        #1;
        checks++; if ({q_loadIn, q_shiftOut, q_clear, q_newVal} !== 4'b0000) $display("[TB] FAIL reset_q_outputs: got %b want 0000", {q_loadIn, q_shiftOut, q_clear, q_newVal}); else passed++;
        checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); else passed++;
        checks++; if (count !== 3'd0 || empty !== 1'b1) $display("[TB] FAIL reset_count: got count=%0d empty=%b want 0/1", count, empty); else passed++;
        @(posedge ck);
        #3;
        r = 1'b1;
        tick();
        checks++; if (q_clear !== 1'b1) $display("[TB] FAIL init_clear_high: got %b want 1", q_clear); else passed++;
        tick();
        checks++; if (q_clear !== 1'b0) $display("[TB] FAIL init_clear_one_cycle: got %b want 0", q_clear); else passed++;
        checks++; if (in_ready !== 1'b1) $display("[TB] FAIL run_in_ready: got %b want 1", in_ready); else passed++;
        checks++; if (count !== 3'd0) $display("[TB] FAIL run_count_zero: got %0d want 0", count); else passed++;
    endtask

    task automatic test_back_to_back();
        vals = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = vals[k];
            tick();
            if (k == 0) begin
                checks++; if (q_loadIn !== 1'b0) $display("[TB] FAIL b2b_first_no_load: got %b want 0", q_loadIn); else passed++;
            end else if (k <= 6) begin
                checks++; if (q_loadIn !== 1'b1 || q_newVal !== vals[k-1]) $display("[TB] FAIL b2b_load_%0d: got load=%b val=%b want 1/%b", k, q_loadIn, q_newVal, vals[k-1]); else passed++;
                checks++; if (count !== 3'(k)) $display("[TB] FAIL b2b_count_%0d: got %0d want %0d", k, count, k); else passed++;
            end else begin
                checks++; if (q_loadIn !== 1'b0 || count !== 3'd6) $display("[TB] FAIL b2b_full_hold: got load=%b count=%0d want 0/6", q_loadIn, count); else passed++;
                checks++; if (in_ready !== 1'b0) $display("[TB] FAIL b2b_in_ready_falls: got %b want 0", in_ready); else passed++;
            end
            if (k == 6) begin
                checks++; if (full !== 1'b1) $display("[TB] FAIL b2b_full_flag: got %b want 1", full); else passed++;
                checks++; if (in_ready !== 1'b1) $display("[TB] FAIL b2b_ready_one_held: got %b want 1", in_ready); else passed++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_pop();
        pop = 1'b1;
        tick();
        checks++; if (q_shiftOut !== 1'b1 || q_loadIn !== 1'b0) $display("[TB] FAIL full_pop_shift: got shift=%b load=%b want 1/0", q_shiftOut, q_loadIn); else passed++;
        checks++; if (count !== 3'd5 || full !== 1'b0) $display("[TB] FAIL full_pop_count: got count=%0d full=%b want 5/0", count, full); else passed++;
        pop = 1'b0;
        tick();
        checks++; if (q_loadIn !== 1'b1 || q_newVal !== 1'b1 || q_shiftOut !== 1'b0) $display("[TB] FAIL held_value_load: got load=%b val=%b shift=%b want 1/1/0", q_loadIn, q_newVal, q_shiftOut); else passed++;
        checks++; if (count !== 3'd6) $display("[TB] FAIL held_value_count: got %0d want 6", count); else passed++;
        tick();
        checks++; if (q_loadIn !== 1'b0 || q_newVal !== 1'b0 || count !== 3'd6) $display("[TB] FAIL full_idle: got load=%b val=%b count=%0d want 0/0/6", q_loadIn, q_newVal, count); else passed++;
    endtask

    task automatic test_pop_with_push();
        do_reset();
        tick();
        tick();
        in_valid = 1'b1; in_data = 1'b0; tick();
        in_data = 1'b1; tick();
        in_data = 1'b0; tick();
        in_valid = 1'b0;
        tick();
        checks++; if (count !== 3'd3 || q_loadIn !== 1'b1 || q_newVal !== 1'b0) $display("[TB] FAIL pp_setup: got count=%0d load=%b val=%b want 3/1/0", count, q_loadIn, q_newVal); else passed++;
        pop = 1'b1; in_valid = 1'b1; in_data = 1'b1;
        tick();
        checks++; if (q_shiftOut !== 1'b1 || q_loadIn !== 1'b0) $display("[TB] FAIL pp_shift_only: got shift=%b load=%b want 1/0", q_shiftOut, q_loadIn); else passed++;
        checks++; if (count !== 3'd2) $display("[TB] FAIL pp_count_after_pop: got %0d want 2", count); else passed++;
        pop = 1'b0; in_valid = 1'b0;
        tick();
        checks++; if (q_loadIn !== 1'b1 || q_newVal !== 1'b1 || q_shiftOut !== 1'b0) $display("[TB] FAIL pp_load_next: got load=%b val=%b shift=%b want 1/1/0", q_loadIn, q_newVal, q_shiftOut); else passed++;
        checks++; if (count !== 3'd3) $display("[TB] FAIL pp_count_after_load: got %0d want 3", count); else passed++;
    endtask

    task automatic test_underflow();
        do_reset();
        tick();
        tick();
        pop = 1'b1;
        tick();
        checks++; if (err_underflow !== 1'b1) $display("[TB] FAIL underflow_pulse: got %b want 1", err_underflow); else passed++;
        checks++; if ({q_loadIn, q_shiftOut, q_clear} !== 3'b000 || count !== 3'd0) $display("[TB] FAIL underflow_no_cmd: got cmds=%b count=%0d want 000/0", {q_loadIn, q_shiftOut, q_clear}, count); else passed++;
        pop = 1'b0;
        tick();
        checks++; if (err_underflow !== 1'b0) $display("[TB] FAIL underflow_one_cycle: got %b want 0", err_underflow); else passed++;
    endtask

    task automatic test_flush();
        vals = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = vals[k];
            tick();
        end
        in_data = vals[6];
        pop     = 1'b1;
        tick();
        checks++; if (count !== 3'd4 || in_ready !== 1'b0) $display("[TB] FAIL flush_setup: got count=%0d ready=%b want 4/0", count, in_ready); else passed++;
        in_valid = 1'b0; pop = 1'b0; flush = 1'b1;
        tick();
        checks++; if ({q_loadIn, q_shiftOut, q_clear} !== 3'b000 || count !== 3'd4) $display("[TB] FAIL flush_enter: got cmds=%b count=%0d want 000/4", {q_loadIn, q_shiftOut, q_clear}, count); else passed++;
        flush = 1'b0;
        tick();
        checks++; if (q_clear !== 1'b1 || q_loadIn !== 1'b0) $display("[TB] FAIL flush_clear: got clear=%b load=%b want 1/0", q_clear, q_loadIn); else passed++;
        checks++; if (count !== 3'd0 || empty !== 1'b1) $display("[TB] FAIL flush_count: got count=%0d empty=%b want 0/1", count, empty); else passed++;
        in_valid = 1'b1; in_data = 1'b1;
        tick();
        checks++; if (q_clear !== 1'b0 || q_loadIn !== 1'b0) $display("[TB] FAIL flush_buffer_emptied: got clear=%b load=%b want 0/0", q_clear, q_loadIn); else passed++;
        in_valid = 1'b0;
        tick();
        checks++; if (q_loadIn !== 1'b1 || q_newVal !== 1'b1 || count !== 3'd1) $display("[TB] FAIL post_flush_load: got load=%b val=%b count=%0d want 1/1/1", q_loadIn, q_newVal, count); else passed++;
        #3;
        r = 1'b0;
        #1;
        checks++; if ({q_loadIn, q_shiftOut, q_clear, q_newVal, in_ready, err_underflow} !== 6'b0 || count !== 3'd0) $display("[TB] FAIL async_reset_outputs: got %b count=%0d want 000000/0", {q_loadIn, q_shiftOut, q_clear, q_newVal, in_ready, err_underflow}, count); else passed++;
        #1;
        r = 1'b1;
        tick();
        checks++; if (q_clear !== 1'b1) $display("[TB] FAIL async_reset_init_clear: got %b want 1", q_clear); else passed++;
        tick();
        checks++; if (q_loadIn !== 1'b0 || count !== 3'd0) $display("[TB] FAIL async_reset_discard: got load=%b count=%0d want 0/0", q_loadIn, count); else passed++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_full_pop();
        test_pop_with_push();
        test_underflow();
        test_flush();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
